// File: rtl/rm802_pkg.sv
// rtl/rm802_pkg.sv - shared types and constants for the rm802 byte-stream demux
package rm802_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_A = 2'd1,
        ROUTE_B = 2'd2
    } state_t;

endpackage

// File: rtl/rm802_out_slot.sv
// rtl/rm802_out_slot.sv - 1-entry valid/ready output register, zero when empty; beat counter under RM802_DEMUX_COUNT_EN
module rm802_out_slot
    import rm802_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef RM802_DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             valid,
    output logic             free
`ifdef RM802_DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    assign free = !valid || ready;

    // A load wins over a drain, so a same-cycle drain+load keeps valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            last  <= load_last;
            valid <= 1'b1;
        end else if (valid && ready) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end
    end

`ifdef RM802_DEMUX_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (valid && ready && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rm802_demux.sv
// rtl/rm802_demux.sv - registered 1-to-2 packet demux; RM802_DEMUX_COUNT_EN adds per-port beat counters
module rm802_demux
    import rm802_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef RM802_DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             busy
`ifdef RM802_DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
`endif
);

    state_t state;
    logic   target_b;
    logic   a_free;
    logic   b_free;
    logic   accept;

    // Only in IDLE does in_select pick the port; afterwards the lock decides.
    always_comb begin
        target_b = 1'b0;
        case (state)
            IDLE:    target_b = (in_select == SEL_B);
            ROUTE_B: target_b = 1'b1;
            default: target_b = 1'b0;
        endcase
    end

    assign in_ready = !enable_n && (target_b ? b_free : a_free);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_last) begin
                        state <= (in_select == SEL_A) ? ROUTE_A : ROUTE_B;
                    end
                end
                ROUTE_A, ROUTE_B: begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rm802_out_slot #(
        .WIDTH(WIDTH)
`ifdef RM802_DEMUX_COUNT_EN
        , .CNT_W(CNT_W)
`endif
    ) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && !target_b),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (a_ready),
        .data      (a_data),
        .last      (a_last),
        .valid     (a_valid),
        .free      (a_free)
`ifdef RM802_DEMUX_COUNT_EN
        , .count   (a_count)
`endif
    );

    rm802_out_slot #(
        .WIDTH(WIDTH)
`ifdef RM802_DEMUX_COUNT_EN
        , .CNT_W(CNT_W)
`endif
    ) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && target_b),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (b_ready),
        .data      (b_data),
        .last      (b_last),
        .valid     (b_valid),
        .free      (b_free)
`ifdef RM802_DEMUX_COUNT_EN
        , .count   (b_count)
`endif
    );

endmodule
